// File: rtl/board_render_sequencer_pkg.sv
// rtl/board_render_sequencer_pkg.sv - shared states, draw codes and frame constants
// Shared with draw_board_datapath so both sides agree on codes and counter wraps.
package board_render_sequencer_pkg;

  localparam int ADDR_W = 6;
  localparam int CODE_W = 6;

  localparam int BRD_NUM_CELLS   = 64;
  localparam int BRD_CELL_PIXELS = 256;
  localparam int BRD_BG_PIXELS   = 32768;

  localparam logic [4:0] CODE_BG    = 5'b11000;
  localparam logic [4:0] CODE_TURN  = 5'b11100;
  localparam logic [4:0] CODE_EMPTY = 5'b00000;
  localparam logic [4:0] CODE_WALL  = 5'b11111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BG    = 3'd1,
    ST_FETCH = 3'd2,
    ST_CELL  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_TURN  = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  function automatic logic [CODE_W-1:0] draw_code(input logic [4:0] code);
    return {1'b0, code};
  endfunction

endpackage

// File: rtl/board_render_sequencer_if.sv
// rtl/board_render_sequencer_if.sv - redraw handshake, datapath drive and board RAM port
// master = sequencer side, slave = requester/datapath/RAM side.
interface board_render_sequencer_if;
  import board_render_sequencer_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic              write;
  logic              update_x_y;
  logic [CODE_W-1:0] draw_value;
  logic [ADDR_W-1:0] ram_addr;
  logic [CODE_W-1:0] ram_rdata;

  modport master (
    input  start, ram_rdata,
    output busy, done, write, update_x_y, draw_value, ram_addr
  );

  modport slave (
    output start, ram_rdata,
    input  busy, done, write, update_x_y, draw_value, ram_addr
  );

endinterface

// File: rtl/board_render_sequencer_pixel_counter.sv
// rtl/board_render_sequencer_pixel_counter.sv - load/enable down-counter with terminal count
// Loaded with N-1 on state entry; tc_o marks the last cycle of the state.
module board_render_sequencer_pixel_counter #(
  parameter int W = 15
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/board_render_sequencer.sv
// rtl/board_render_sequencer.sv - redraw FSM: background, 64 fetched cells, turn indicator
// All outputs are registered from next-state values so they line up with the state.
module board_render_sequencer
  import board_render_sequencer_pkg::*;
#(
  parameter int BG_PIXELS   = BRD_BG_PIXELS,
  parameter int CELL_PIXELS = BRD_CELL_PIXELS,
  parameter int NUM_CELLS   = BRD_NUM_CELLS,
  parameter int RAM_LAT     = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  board_render_sequencer_if.master   ctrl_io
);

  localparam int PIX_W = (BG_PIXELS > 2) ? $clog2(BG_PIXELS) : 1;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_CELLS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cell_q, cell_d;
  logic              pend_q, pend_d;
  logic [CODE_W-1:0] code_q, code_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              write_q, write_d;
  logic              upd_q, upd_d;
  logic [CODE_W-1:0] draw_q, draw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              cnt_load, cnt_en, cnt_tc;
  logic [PIX_W-1:0]  cnt_val;

  board_render_sequencer_pixel_counter #(.W(PIX_W)) u_pix (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .tc_o       (cnt_tc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cell_q  <= '0;
      pend_q  <= 1'b0;
      code_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      write_q <= 1'b0;
      upd_q   <= 1'b0;
      draw_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cell_q  <= cell_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      write_q <= write_d;
      upd_q   <= upd_d;
      draw_q  <= draw_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cell_d  = cell_q;
    pend_d  = pend_q;
    code_d  = code_q;
    // Requests during a frame collapse into a single follow-on frame.
    if ((state_q != ST_IDLE) && ctrl_io.start) begin
      pend_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (ctrl_io.start) begin
          state_d = ST_BG;
          cell_d  = '0;
        end
      end
      ST_BG:    if (cnt_tc) state_d = ST_FETCH;
      ST_FETCH: begin
        if (cnt_tc) begin
          state_d = ST_CELL;
          code_d  = ctrl_io.ram_rdata;
        end
      end
      ST_CELL:  if (cnt_tc) state_d = ST_NEXT;
      ST_NEXT: begin
        cell_d  = cell_q + ADDR_W'(1);
        state_d = (cell_q == LAST_CELL) ? ST_TURN : ST_FETCH;
      end
      ST_TURN:  if (cnt_tc) state_d = ST_DONE;
      ST_DONE: begin
        pend_d = 1'b0;
        if (pend_q || ctrl_io.start) begin
          state_d = ST_BG;
          cell_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_load = (state_d != state_q);
    cnt_en   = (state_q == ST_BG) || (state_q == ST_FETCH) ||
               (state_q == ST_CELL) || (state_q == ST_TURN);
    case (state_d)
      ST_BG:            cnt_val = PIX_W'(BG_PIXELS - 1);
      ST_FETCH:         cnt_val = PIX_W'(RAM_LAT - 1);
      ST_CELL, ST_TURN: cnt_val = PIX_W'(CELL_PIXELS - 1);
      default:          cnt_val = '0;
    endcase
  end

  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    write_d = (state_d == ST_BG) || (state_d == ST_CELL) || (state_d == ST_TURN);
    upd_d   = (state_d == ST_NEXT);
    case (state_d)
      ST_BG:   draw_d = draw_code(CODE_BG);
      ST_TURN: draw_d = draw_code(CODE_TURN);
      default: draw_d = code_d;
    endcase
    // Present the next cell address during NEXT so RAM data is ready by the end of FETCH.
    addr_d = (state_d == ST_NEXT) ? (cell_q + ADDR_W'(1)) : cell_d;
  end

  assign ctrl_io.busy       = busy_q;
  assign ctrl_io.done       = done_q;
  assign ctrl_io.write      = write_q;
  assign ctrl_io.update_x_y = upd_q;
  assign ctrl_io.draw_value = draw_q;
  assign ctrl_io.ram_addr   = addr_q;

endmodule
